xilinx_sdp_bram_reader: RTL
===========================

Name: xilinx_sdp_bram_reader

Overview:
- Read-side engine for the simple-dual-port BRAM wrapper. Turns a start command (base address, word count) into a burst of RDEN/RDADDR/REGCE cycles on the BRAM read port.
- Absorbs the fixed BRAM read latency (1 + DO_REG) in a credit-controlled skid FIFO and presents the words as a valid/ready stream with a last flag.
- Counterpart of the write-side producer that fills the BRAM through WRCLK/WREN/WE. Instantiated once per BRAM read port, in the RDCLK domain.

Parameters:
- READ_WIDTH, 32, data width; must match the wrapper's READ_WIDTH (1-72).
- ADDR_WIDTH, 15, significant RDADDR bits. Upper RDADDR bits are driven 0.
- DO_REG, 0, must match the wrapper's DO_REG. Read latency LAT = 1 + DO_REG.
- LEN_WIDTH, 16, width of the burst length field.
- SKID_DEPTH, 4, FIFO entries. Legal range is LAT+1 up to 16; values below LAT+1 are an elaboration error.

Ports:
- CLK  in  1  single clock; connect the same net as the wrapper's RDCLK.
- RST  in  1  synchronous, active-high reset.
- START  in  1  command strobe; accepted only when BUSY=0.
- START_ADDR  in  ADDR_WIDTH  first word address.
- START_LEN  in  LEN_WIDTH  number of words to read; 0 is legal.
- BUSY  out  1  high from the cycle after an accepted START until DONE.
- DONE  out  1  one-cycle pulse when the burst completes.
- RDADDR  out  15  BRAM read address.
- RDEN  out  1  BRAM read enable.
- REGCE  out  1  BRAM output register enable.
- DO  in  READ_WIDTH  BRAM read data.
- M_DATA  out  READ_WIDTH  stream data.
- M_VALID  out  1  stream valid.
- M_READY  in  1  stream ready.
- M_LAST  out  1  high with the final word of the burst.

Behaviour:
- Reset values: BUSY, DONE, RDEN, REGCE, M_VALID, M_LAST = 0; RDADDR = 0; M_DATA = 0. Reset also clears the FIFO, the latency pipe and all counters.
- RST asserted mid-burst aborts the burst immediately. No DONE pulse. Data already in flight from the BRAM is discarded.
- FSM states:
  - IDLE: START=1 latches addr/len and goes to RUN. If len=0, go to DONE_ST instead.
  - RUN: issues reads. When all len reads are issued, go to DRAIN.
  - DRAIN: waits until the final word completes its M_VALID&M_READY handshake, then goes to DONE_ST.
  - DONE_ST: DONE=1 for one cycle, then IDLE.
- BUSY=1 in RUN, DRAIN and DONE_ST. START is ignored while BUSY=1.
- Issue rule, evaluated each cycle in RUN: RDEN = (issued < len) && (inflight + fifo_count < SKID_DEPTH).
  - A pop in the same cycle is not credited.
  - On an issue, RDADDR increments modulo 2^ADDR_WIDTH; the address wraps silently, e.g. 0x7FFF is followed by 0x0000.
- RDADDR holds the current address (START_ADDR + issued). Its value is meaningful only when RDEN=1.
- Latency pipe: a shift register of LAT valid bits, tagged with a last bit.
  - When DO_REG=1: REGCE = pipe stage-0 valid, i.e. asserted the cycle after the matching RDEN. When DO_REG=0: REGCE = 0.
  - DO is written into the FIFO in the cycle the pipe tail bit is valid.
- FIFO: registered outputs. M_VALID = FIFO not empty. M_DATA and M_LAST come from the FIFO head.
  - M_DATA and M_LAST are held stable while M_VALID=1 and M_READY=0.
- Throughput: 1 word/cycle with M_READY held high. First-word latency is LAT+2 cycles after the START cycle.
- Overflow is impossible by construction of the credit rule. The bench asserts that no FIFO write occurs while the FIFO is full.
- A simultaneous FIFO push and pop when full or empty is handled by the FIFO.
- Counter widths: issued and popped are LEN_WIDTH+1 bits; inflight is $clog2(LAT+1) bits.

Decomposition:
- xilinx_primitive_pkg gains:
  - typedef enum sdp_rd_state_t {IDLE, RUN, DRAIN, DONE_ST}
  - function sdp_rd_latency(do_reg) returning 1+do_reg.
- One sub-module: xilinx_sync_fifo. Parameters WIDTH and DEPTH. Ports CLK, RST, WR_EN, WR_DATA, FULL, RD_EN, RD_DATA, EMPTY, COUNT.
  - Instantiated with WIDTH = READ_WIDTH+1, carrying data plus last.

Test Plan:
- DO_REG=0, BRAM preloaded with 0x100+i at address i, START addr=0x10 len=8, M_READY=1 -> M_DATA 0x110..0x117 on consecutive cycles. First M_VALID 3 cycles after START. M_LAST on 0x117. DONE one cycle after the last handshake.
- DO_REG=1, same stimulus -> REGCE high exactly one cycle after each RDEN. First M_VALID 4 cycles after START. Data and order identical to the first case.
- Backpressure: len=20, M_READY toggling 1 cycle on / 3 off -> no words lost or duplicated. The number of RDEN cycles not yet popped never exceeds SKID_DEPTH. Data is stable while stalled.
- Wrap: addr=0x7FFE, len=4 -> RDADDR sequence 0x7FFE, 0x7FFF, 0x0000, 0x0001, and the matching data.
- len=0 -> no RDEN, no M_VALID, BUSY high for exactly 1 cycle, DONE pulse 1 cycle after START. A second START issued while BUSY is ignored.
- RST asserted after 5 of 10 words -> next cycle all outputs are 0 and the FIFO is empty. A new START of len=2 then completes cleanly with correct data and no stale words.

Source files
------------

// File: rtl/xilinx_primitive_pkg.sv
// ----------------------------------------------------------------------------
// xilinx_primitive_pkg
//   Shared types and helpers for the Xilinx primitive wrappers and the engines
//   that drive them.
//
//   sdp_rd_state_t  : control states of the simple-dual-port BRAM read engine.
//   sdp_rd_latency(): BRAM read latency in cycles for a given DO_REG setting
//                     (one cycle for the array plus one for the optional
//                     output register).
// ----------------------------------------------------------------------------
package xilinx_primitive_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DRAIN   = 2'd2,
        DONE_ST = 2'd3
    } sdp_rd_state_t;

    function automatic int sdp_rd_latency(input int do_reg);
        return 1 + do_reg;
    endfunction

endpackage

// File: rtl/xilinx_sync_fifo.sv
// ----------------------------------------------------------------------------
// xilinx_sync_fifo
//   Small single-clock first-word-fall-through FIFO with a registered head.
//   The head entry is always held in an output register, so RD_DATA comes
//   straight from a flop and stays stable until the entry is popped.
//
//   Ports
//     CLK      in   clock
//     RST      in   synchronous active-high reset (empties the FIFO, RD_DATA=0)
//     WR_EN    in   push request; accepted when not full, or when full with a
//                   simultaneous pop
//     WR_DATA  in   WIDTH   data to push
//     FULL     out  COUNT == DEPTH
//     RD_EN    in   pop request; ignored when empty
//     RD_DATA  out  WIDTH   head entry (meaningful when EMPTY=0)
//     EMPTY    out  COUNT == 0
//     COUNT    out  number of stored entries
// ----------------------------------------------------------------------------
module xilinx_sync_fifo #(
    parameter  int WIDTH = 33,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WR_EN,
    input  logic [WIDTH-1:0] WR_DATA,
    output logic             FULL,
    input  logic             RD_EN,
    output logic [WIDTH-1:0] RD_DATA,
    output logic             EMPTY,
    output logic [CNT_W-1:0] COUNT
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign FULL    = (count_q == CNT_W'(DEPTH));
    assign EMPTY   = (count_q == '0);
    assign COUNT   = count_q;
    assign RD_DATA = head_q;

    assign pop  = RD_EN && !EMPTY;
    // A pop frees a slot in the same cycle, so a full FIFO can still take a
    // push alongside it. The slot being overwritten is the one leaving.
    assign push = WR_EN && (!FULL || pop);

    always_comb begin
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        head_d   = head_q;
        if (push && ((count_q == '0) || (pop && (count_q == CNT_W'(1))))) begin
            // Nothing else stored after this cycle's pop: new word is the head.
            head_d = WR_DATA;
        end else if (pop && (count_q != CNT_W'(1))) begin
            // Next older entry is already in the array.
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= WR_DATA;
        end
    end

endmodule

// File: rtl/xilinx_sdp_bram_reader.sv
// ----------------------------------------------------------------------------
// xilinx_sdp_bram_reader
//   Read-side engine for the simple-dual-port BRAM wrapper. A START command
//   (address, length) becomes a burst of RDEN/RDADDR (and REGCE when the
//   output register is used) on the BRAM read port. Returning words are
//   absorbed in a credit-controlled skid FIFO and presented as a valid/ready
//   stream with a last flag. Runs entirely in the BRAM RDCLK domain.
//
//   Ports
//     CLK         in   clock (same net as the wrapper RDCLK)
//     RST         in   synchronous active-high reset; aborts any burst
//     START       in   command strobe, accepted only when BUSY=0
//     START_ADDR  in   ADDR_WIDTH  first word address
//     START_LEN   in   LEN_WIDTH   number of words (0 allowed)
//     BUSY        out  high from the cycle after an accepted START until DONE
//     DONE        out  one-cycle completion pulse
//     RDADDR      out  15  BRAM read address (upper bits zero)
//     RDEN        out  BRAM read enable
//     REGCE       out  BRAM output register enable (DO_REG=1 only)
//     DO          in   READ_WIDTH  BRAM read data
//     M_DATA      out  READ_WIDTH  stream data
//     M_VALID     out  stream valid
//     M_READY     in   stream ready
//     M_LAST      out  final word of the burst
// ----------------------------------------------------------------------------
module xilinx_sdp_bram_reader
    import xilinx_primitive_pkg::*;
#(
    parameter int READ_WIDTH = 32,
    parameter int ADDR_WIDTH = 15,
    parameter int DO_REG     = 0,
    parameter int LEN_WIDTH  = 16,
    parameter int SKID_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [ADDR_WIDTH-1:0] START_ADDR,
    input  logic [LEN_WIDTH-1:0]  START_LEN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [14:0]           RDADDR,
    output logic                  RDEN,
    output logic                  REGCE,
    input  logic [READ_WIDTH-1:0] DO,
    output logic [READ_WIDTH-1:0] M_DATA,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic                  M_LAST
);

    localparam int LAT   = sdp_rd_latency(DO_REG);
    localparam int CW    = LEN_WIDTH + 1;
    localparam int INF_W = $clog2(LAT + 1);
    localparam int FCW   = $clog2(SKID_DEPTH + 1);

    generate
        if ((SKID_DEPTH < LAT + 1) || (SKID_DEPTH > 16)) begin : g_bad_depth
            $error("SKID_DEPTH must lie between LAT+1 and 16");
        end
        if ((ADDR_WIDTH < 1) || (ADDR_WIDTH > 15)) begin : g_bad_addr
            $error("ADDR_WIDTH must lie between 1 and 15");
        end
        if ((READ_WIDTH < 1) || (READ_WIDTH > 72)) begin : g_bad_width
            $error("READ_WIDTH must lie between 1 and 72");
        end
    endgenerate

    sdp_rd_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         len_q, len_d;
    logic [CW-1:0]         issued_q, issued_d;
    logic [CW-1:0]         popped_q, popped_d;
    logic [INF_W-1:0]      inflight_q, inflight_d;
    logic [LAT-1:0]        pipe_valid_q, pipe_valid_d;
    logic [LAT-1:0]        pipe_last_q, pipe_last_d;

    logic                  issue, issue_last, pop;
    logic [31:0]           credit_used;

    logic                  fifo_wr, fifo_full, fifo_empty;
    logic [READ_WIDTH:0]   fifo_rd;
    logic [FCW-1:0]        fifo_count;

    // Every word either sits in the latency pipe or in the FIFO; a read may
    // only be issued while that total leaves a free FIFO slot. A pop in the
    // same cycle is deliberately not credited so issue never depends on
    // M_READY combinationally.
    assign credit_used = 32'(inflight_q) + 32'(fifo_count);
    assign issue       = (state_q == RUN) && (issued_q < len_q) &&
                         (credit_used < 32'(SKID_DEPTH)) && !fifo_full;
    assign issue_last  = issue && ((issued_q + CW'(1)) == len_q);
    assign pop         = !fifo_empty && M_READY;

    // Latency pipe: one valid/last tag per outstanding BRAM read.
    assign pipe_valid_d[0] = issue;
    assign pipe_last_d[0]  = issue_last;
    for (genvar gi = 1; gi < LAT; gi++) begin : g_pipe
        assign pipe_valid_d[gi] = pipe_valid_q[gi-1];
        assign pipe_last_d[gi]  = pipe_last_q[gi-1];
    end

    // DO is valid in the cycle the tail tag is set.
    assign fifo_wr    = pipe_valid_q[LAT-1];
    assign inflight_d = inflight_q + INF_W'(issue) - INF_W'(fifo_wr);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        issued_d = issued_q;
        popped_d = popped_q;
        if (issue) begin
            addr_d   = addr_q + ADDR_WIDTH'(1);
            issued_d = issued_q + CW'(1);
        end
        if (pop) begin
            popped_d = popped_q + CW'(1);
        end
        case (state_q)
            IDLE: begin
                if (START) begin
                    addr_d   = START_ADDR;
                    len_d    = {1'b0, START_LEN};
                    issued_d = '0;
                    popped_d = '0;
                    state_d  = (START_LEN == '0) ? DONE_ST : RUN;
                end
            end
            RUN: begin
                if (issued_d == len_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (popped_d == len_q)) begin
                    state_d = DONE_ST;
                end
            end
            DONE_ST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            issued_q     <= '0;
            popped_q     <= '0;
            inflight_q   <= '0;
            pipe_valid_q <= '0;
            pipe_last_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            issued_q     <= issued_d;
            popped_q     <= popped_d;
            inflight_q   <= inflight_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_last_q  <= pipe_last_d;
        end
    end

    xilinx_sync_fifo #(
        .WIDTH (READ_WIDTH + 1),
        .DEPTH (SKID_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .WR_EN   (fifo_wr),
        .WR_DATA ({pipe_last_q[LAT-1], DO}),
        .FULL    (fifo_full),
        .RD_EN   (pop),
        .RD_DATA (fifo_rd),
        .EMPTY   (fifo_empty),
        .COUNT   (fifo_count)
    );

    generate
        if (DO_REG != 0) begin : g_regce
            // Output register captures the array output one cycle after RDEN.
            assign REGCE = pipe_valid_q[0];
        end else begin : g_no_regce
            assign REGCE = 1'b0;
        end
    endgenerate

    assign BUSY    = (state_q != IDLE);
    assign DONE    = (state_q == DONE_ST);
    assign RDEN    = issue;
    assign RDADDR  = 15'(addr_q);
    assign M_VALID = !fifo_empty;
    assign M_DATA  = fifo_rd[READ_WIDTH-1:0];
    assign M_LAST  = fifo_rd[READ_WIDTH];

endmodule
